// File: rtl/bot_index_sequencer.sv
// Bottom-index source: issues START + k*STRIDE under a valid/request handshake
// with a transfer-clocked expected-index tap. Define BOT_INDEX_SEQ_LOOP_EN to loop passes.
module bot_index_sequencer #(
  parameter int INDEX_WIDTH = 15,
  parameter int COUNT       = 32000,
  parameter int START       = 0,
  parameter int STRIDE      = 1,
  parameter int LATENCY     = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   requestData,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   dataAvailable,
  output logic                   done,
  output logic [23:0]            issuedCount,
  output logic [INDEX_WIDTH-1:0] expIndex,
  output logic                   expValid,
  output logic [15:0]            passCount,
  output logic [1:0]             fsm_state
);

  localparam int PTR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int OCC_W = $clog2(LATENCY + 1);
  localparam logic [INDEX_WIDTH-1:0] START_IDX  = INDEX_WIDTH'(START);
  localparam logic [INDEX_WIDTH-1:0] STRIDE_IDX = INDEX_WIDTH'(STRIDE);
  localparam logic [23:0]            COUNT_LAST = 24'(COUNT - 1);

`ifdef BOT_INDEX_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  // Handshake: a transfer happens exactly in a cycle where dataAvailable && requestData;
  // the consumer may hold requestData low indefinitely and every output then holds.
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;
  logic   xfer;
  logic   pass_end;

  assign dataAvailable = (state == S_RUN);
  assign fsm_state     = state;
  assign xfer          = dataAvailable && requestData;
  assign pass_end      = xfer && (issuedCount == COUNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_RESET;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_RUN;
      S_RUN:   if (pass_end && !LOOP_EN) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index       <= START_IDX;
      issuedCount <= '0;
      done        <= 1'b0;
    end else begin
      // Looping builds pulse done per pass; otherwise it latches until reset.
      if (LOOP_EN)       done <= pass_end;
      else if (pass_end) done <= 1'b1;
      if (xfer) begin
        if (pass_end && LOOP_EN) begin
          index       <= START_IDX;
          issuedCount <= '0;
        end else begin
          index       <= index + STRIDE_IDX;
          issuedCount <= issuedCount + 24'd1;
        end
      end
    end
  end

  // Expected tap: circular buffer; once full, each transfer reads the oldest
  // entry and overwrites the same slot with the newly transferred index.
  logic [INDEX_WIDTH-1:0] tap_mem [LATENCY];
  logic [PTR_W-1:0]       tap_ptr;
  logic [OCC_W-1:0]       tap_occ;
  logic                   tap_full;

  assign tap_full = (tap_occ == OCC_W'(LATENCY));

  always_ff @(posedge clk) begin
    if (xfer) tap_mem[tap_ptr] <= index;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_ptr  <= '0;
      tap_occ  <= '0;
      expIndex <= '0;
      expValid <= 1'b0;
    end else if (xfer) begin
      tap_ptr <= (tap_ptr == PTR_W'(LATENCY - 1)) ? '0 : tap_ptr + PTR_W'(1);
      if (tap_full) begin
        expIndex <= tap_mem[tap_ptr];
        expValid <= 1'b1;
      end else begin
        tap_occ <= tap_occ + OCC_W'(1);
      end
    end
  end

`ifdef BOT_INDEX_SEQ_LOOP_EN
  always_ff @(posedge clk) begin
    if (rst)                                   passCount <= '0;
    else if (pass_end && passCount != 16'hFFFF) passCount <= passCount + 16'd1;
  end
`else
  assign passCount = '0;
`endif

endmodule

// File: doc/bot_index_sequencer.md
# bot_index_sequencer

Parametrised bottom-index source for the full-pipeline benches and bring-up harnesses. It issues a stream of INDEX_WIDTH-bit indices under a valid/request handshake driven by the pipeline's almostFull back-pressure. It also exposes a fixed-latency expected-index tap that lines up with the pipeline output, so checkers compare against a registered index instead of a hand-computed offset. It replaces the single-purpose linear index provider: start, stride, count and latency are generic, and the source can optionally loop.

## Interface
- INDEX_WIDTH, 15: width of the issued index.
- COUNT, 32000: indices issued per pass; must be ≥1 and < 2^24.
- START, 0: first index of each pass.
- STRIDE, 1: per-transfer increment, modulo 2^INDEX_WIDTH.
- LATENCY, 4096: depth of the expected-index delay line in transfers; must be ≥1.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- requestData  in  1  consumer can accept an index this cycle (driven by !almostFull).
- index  out  INDEX_WIDTH  current index, valid while dataAvailable=1.
- dataAvailable  out  1  index is valid.
- done  out  1  pass complete; level output, or a one-cycle pulse when looping.
- issuedCount  out  24  transfers completed in the current pass.
- expIndex  out  INDEX_WIDTH  index transferred LATENCY transfers earlier.
- expValid  out  1  expIndex holds a real index, meaning at least LATENCY+1 transfers have occurred since reset.
- passCount  out  16  completed passes; stays 0 unless looping is compiled in.

## Operation
- A transfer occurs in a cycle where dataAvailable && requestData. There is no other way to advance.
- On a transfer:
  - index ← index + STRIDE, truncated to INDEX_WIDTH, so it wraps silently.
  - issuedCount increments.
- After the transfer where issuedCount reaches COUNT, the pass ends:
  - without loop: dataAvailable ← 0, done ← 1, and both hold until reset.
  - with loop: see Configuration.
- Expected tap: a LATENCY-deep FIFO of indices with an occupancy counter.
  - On each transfer, push the transferred index.
  - When occupancy equals LATENCY, the same transfer also pops.
  - expIndex is the last popped value. expValid goes to 1 on the first pop and then stays 1.
  - The tap advances only on transfers. Stall cycles do not shift it.
- States: RESET, RUN (dataAvailable=1), DONE (dataAvailable=0).
  - RESET goes to RUN on the first cycle after rst deasserts.
  - RUN goes to DONE at the end of a pass, without loop.
  - DONE holds.
- Reset mid-operation discards all in-flight state. The FIFO occupancy clears and expValid drops.

## Timing
- Reset values:
  - index=START
  - dataAvailable=0, done=0
  - issuedCount=0, passCount=0
  - expIndex=0, expValid=0
- dataAvailable=1 on the first clk edge after rst is sampled low.
- index, dataAvailable, done, issuedCount and passCount are registered. requestData has a combinational effect only on the next-state logic, not on the outputs.
- Sustained throughput is 1 index per cycle while requestData=1.
- requestData low freezes every output. Toggling requestData every cycle yields exactly one transfer per high cycle.
- expIndex/expValid update on the edge that ends the LATENCY+1-th and later transfers.
- Pass end and a stall in the same cycle: no transfer occurs, so the pass does not end.

## Configuration
- BOT_INDEX_SEQ_LOOP_EN defined, at the transfer that completes a pass:
  - index ← START
  - issuedCount ← 0
  - passCount increments, saturating at 0xFFFF
  - done pulses high for one cycle
  - dataAvailable stays 1 with no bubble
  - the expected tap continues across the pass boundary
- Undefined: sequencer stops in DONE as described, and passCount is tied to 0.

## Test plan
- Defaults, requestData=1 always:
  - indices 0..31999 on consecutive cycles after reset.
  - done=1 and dataAvailable=0 on the cycle after index 31999 transfers.
  - issuedCount=32000.
- Back-pressure, requestData random at 50% duty:
  - the index sequence is identical to the unstalled run, with no skips and no repeats.
  - the count of requestData=1 cycles while dataAvailable=1 equals 32000.
- Expected tap with LATENCY=4096:
  - expValid rises after transfer 4097.
  - from then on, expIndex equals index−4096 at every transfer.
- Wrap, INDEX_WIDTH=4, START=14, STRIDE=3, COUNT=6 -> sequence 14, 1, 4, 7, 10, 13, then DONE.
- Reset mid-run: rst=1 for one cycle at issuedCount=100 ->
  - next cycle index=START, issuedCount=0, expValid=0.
  - the full sequence repeats.
- With BOT_INDEX_SEQ_LOOP_EN, COUNT=5, START=2:
  - sequence 2..6, 2..6, and so on, with no gap cycle.
  - done is a one-cycle pulse with each transfer of 6.
  - passCount=3 after 15 transfers.
